// File: rtl/cnn_pkg.sv
// Shared CNN cell-array types: pixel width and signed pixel type.
package cnn_pkg;

    localparam int unsigned WIDTH = 9;

    typedef logic signed [WIDTH-1:0] cnn_pix_t;

endpackage : cnn_pkg

// File: rtl/cnn_line_buf.sv
// Fixed-depth shift delay line: dout is the sample shifted in DEPTH enables ago.
module cnn_line_buf
    import cnn_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] din,
    output logic signed [WIDTH-1:0] dout
);

    cnn_pix_t [DEPTH-1:0] mem_q;
    cnn_pix_t [DEPTH-1:0] mem_d;

    // Shift one position towards the output on every enable.
    always_comb begin
        mem_d = mem_q;
        if (en) begin
            mem_d = {mem_q[DEPTH-2:0], din};
        end
    end

    // Delay-line storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign dout = mem_q[DEPTH-1];

endmodule : cnn_line_buf

// File: rtl/cnn_window_gen.sv
// Streaming 3x3 window generator with fixed-boundary padding for the CNN cell array.
module cnn_window_gen
    import cnn_pkg::*;
#(
    parameter int unsigned IMG_W = 8,
    parameter int unsigned IMG_H = 8,
    parameter cnn_pix_t    BOUND = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic signed [WIDTH-1:0] w1,
    output logic signed [WIDTH-1:0] w2,
    output logic signed [WIDTH-1:0] w3,
    output logic signed [WIDTH-1:0] w4,
    output logic signed [WIDTH-1:0] w5,
    output logic signed [WIDTH-1:0] w6,
    output logic signed [WIDTH-1:0] w7,
    output logic signed [WIDTH-1:0] w8,
    output logic signed [WIDTH-1:0] w9,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last
);

    localparam int unsigned N      = IMG_W * IMG_H;
    localparam int unsigned P_LAST = N + IMG_W;
    localparam int unsigned PW     = $clog2(P_LAST + 1);
    localparam int unsigned CW     = $clog2(IMG_W);
    localparam int unsigned RW     = $clog2(IMG_H);

    typedef enum logic [1:0] {
        S_FILL,
        S_RUN,
        S_FLUSH
    } state_e;

    state_e               state_q, state_d;
    logic [PW-1:0]        p_q, p_d;
    logic [RW-1:0]        rc_q, rc_d;
    logic [CW-1:0]        cc_q, cc_d;
    cnn_pix_t [0:2][0:2]  win_q, win_d;
    cnn_pix_t [0:2][0:2]  out_win_q, out_win_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;

    logic                 adv;
    logic                 emit;
    logic                 out_free;
    cnn_pix_t             new_pix;
    cnn_pix_t             lb1_out;
    cnn_pix_t             lb2_out;

    // Line buffer 1 delays the stream by one row, line buffer 2 by a second row.
    cnn_line_buf #(.DEPTH(IMG_W)) u_lb1 (
        .clk  (clk),
        .rst  (rst),
        .en   (adv),
        .din  (new_pix),
        .dout (lb1_out)
    );

    cnn_line_buf #(.DEPTH(IMG_W)) u_lb2 (
        .clk  (clk),
        .rst  (rst),
        .en   (adv),
        .din  (lb1_out),
        .dout (lb2_out)
    );

    // Advance control, window shift, boundary masking and output register load.
    always_comb begin
        state_d     = state_q;
        p_d         = p_q;
        rc_d        = rc_q;
        cc_d        = cc_q;
        win_d       = win_q;
        out_win_d   = out_win_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_free    = !out_valid_q || out_ready;
        in_ready    = 1'b0;
        adv         = 1'b0;
        emit        = 1'b0;
        new_pix     = BOUND;

        case (state_q)
            S_FILL: begin
                in_ready = 1'b1;
                adv      = in_valid;
                new_pix  = in_data;
                if (adv && p_q == PW'(IMG_W)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                in_ready = out_free;
                adv      = in_valid && out_free;
                emit     = adv;
                new_pix  = in_data;
                if (adv && p_q == PW'(N - 1)) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                adv  = out_free;
                emit = adv;
                if (adv && p_q == PW'(P_LAST)) begin
                    state_d = S_FILL;
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (adv) begin
            for (int i = 0; i < 3; i++) begin
                win_d[i][0] = win_q[i][1];
                win_d[i][1] = win_q[i][2];
            end
            win_d[0][2] = lb2_out;
            win_d[1][2] = lb1_out;
            win_d[2][2] = new_pix;
            if (state_q == S_FLUSH && p_q == PW'(P_LAST)) begin
                p_d = '0;
            end else begin
                p_d = p_q + PW'(1);
            end
        end

        if (emit) begin
            // Out-of-image neighbours take BOUND, which also hides stale line-buffer data.
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    if ((j == 0 && cc_q == CW'(0)) ||
                        (j == 2 && cc_q == CW'(IMG_W - 1)) ||
                        (i == 0 && rc_q == RW'(0)) ||
                        (i == 2 && rc_q == RW'(IMG_H - 1))) begin
                        out_win_d[i][j] = BOUND;
                    end else begin
                        out_win_d[i][j] = win_d[i][j];
                    end
                end
            end
            out_valid_d = 1'b1;
            out_last_d  = (rc_q == RW'(IMG_H - 1)) && (cc_q == CW'(IMG_W - 1));
            if (cc_q == CW'(IMG_W - 1)) begin
                cc_d = '0;
                if (rc_q == RW'(IMG_H - 1)) begin
                    rc_d = '0;
                end else begin
                    rc_d = rc_q + RW'(1);
                end
            end else begin
                cc_d = cc_q + CW'(1);
            end
        end
    end

    // State, counters, window array and output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_FILL;
            p_q         <= '0;
            rc_q        <= '0;
            cc_q        <= '0;
            win_q       <= '0;
            out_win_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            p_q         <= p_d;
            rc_q        <= rc_d;
            cc_q        <= cc_d;
            win_q       <= win_d;
            out_win_q   <= out_win_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign w1        = out_win_q[0][0];
    assign w2        = out_win_q[0][1];
    assign w3        = out_win_q[0][2];
    assign w4        = out_win_q[1][0];
    assign w5        = out_win_q[1][1];
    assign w6        = out_win_q[1][2];
    assign w7        = out_win_q[2][0];
    assign w8        = out_win_q[2][1];
    assign w9        = out_win_q[2][2];
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

endmodule : cnn_window_gen

// File: tb/tb_cnn_window_gen.sv
// Scoreboard bench for cnn_window_gen: BOUND=0 and BOUND=-256 instances on one stream.
module tb_cnn_window_gen;

    localparam int IMG_W = 4;
    localparam int IMG_H = 3;
    localparam int N     = IMG_W * IMG_H;

    typedef struct packed {
        logic             last;
        logic [8:0][8:0]  w;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [8:0]  in_data;
    logic               in_valid;
    logic               out_ready;

    logic               d0_in_ready, d0_valid, d0_last;
    logic               d1_in_ready, d1_valid, d1_last;
    logic signed [8:0]  d0_w [9];
    logic signed [8:0]  d1_w [9];

    exp_t q0[$];
    exp_t q1[$];
    exp_t log0 [64];
    exp_t log1 [64];
    int   total0 = 0;
    int   total1 = 0;
    int   n_cmp  = 0;
    int   n_err  = 0;

    always #5 clk = ~clk;

    cnn_window_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .BOUND(9'sd0)) dut0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(d0_in_ready),
        .w1(d0_w[0]), .w2(d0_w[1]), .w3(d0_w[2]), .w4(d0_w[3]), .w5(d0_w[4]),
        .w6(d0_w[5]), .w7(d0_w[6]), .w8(d0_w[7]), .w9(d0_w[8]),
        .out_valid(d0_valid), .out_ready(out_ready), .out_last(d0_last)
    );

    cnn_window_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .BOUND(9'sh100)) dut1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(d1_in_ready),
        .w1(d1_w[0]), .w2(d1_w[1]), .w3(d1_w[2]), .w4(d1_w[3]), .w5(d1_w[4]),
        .w6(d1_w[5]), .w7(d1_w[6]), .w8(d1_w[7]), .w9(d1_w[8]),
        .out_valid(d1_valid), .out_ready(out_ready), .out_last(d1_last)
    );

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference window for centre index k of a frame whose pixel n is base+n+1.
    function automatic exp_t model(input int base, input int k, input int bnd);
        exp_t e;
        int r, c, rr, cc, v;
        r = k / IMG_W;
        c = k % IMG_W;
        e.last = (k == N - 1);
        for (int i = 0; i < 9; i++) begin
            rr = r + i / 3 - 1;
            cc = c + i % 3 - 1;
            if (rr < 0 || rr >= IMG_H || cc < 0 || cc >= IMG_W) v = bnd;
            else v = base + rr * IMG_W + cc + 1;
            e.w[i] = 9'(v);
        end
        return e;
    endfunction

    // Pop and compare every window handed over on an output handshake.
    always @(negedge clk) begin
        exp_t e;
        exp_t o;
        if (!rst && d0_valid && out_ready) begin
            for (int i = 0; i < 9; i++) o.w[i] = d0_w[i];
            o.last = d0_last;
            if (q0.size() == 0) begin
                check_val("d0_unexpected_window", 1, 0);
            end else begin
                e = q0.pop_front();
                for (int i = 0; i < 9; i++)
                    check_val($sformatf("d0_w%0d[%0d]", i + 1, total0), int'(d0_w[i]), int'($signed(e.w[i])));
                check_val($sformatf("d0_last[%0d]", total0), int'(d0_last), int'(e.last));
            end
            if (total0 < 64) log0[total0] = o;
            total0++;
        end
        if (!rst && d1_valid && out_ready) begin
            for (int i = 0; i < 9; i++) o.w[i] = d1_w[i];
            o.last = d1_last;
            if (q1.size() == 0) begin
                check_val("d1_unexpected_window", 1, 0);
            end else begin
                e = q1.pop_front();
                for (int i = 0; i < 9; i++)
                    check_val($sformatf("d1_w%0d[%0d]", i + 1, total1), int'(d1_w[i]), int'($signed(e.w[i])));
                check_val($sformatf("d1_last[%0d]", total1), int'(d1_last), int'(e.last));
            end
            if (total1 < 64) log1[total1] = o;
            total1++;
        end
    end

    task automatic check_lit(input string tag, input exp_t got, input int v [9]);
        for (int i = 0; i < 9; i++)
            check_val($sformatf("%s_w%0d", tag, i + 1), int'($signed(got.w[i])), v[i]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_val("rst_out_valid", int'(d0_valid), 0);
        check_val("rst_out_last", int'(d0_last), 0);
        check_val("rst_d1_out_valid", int'(d1_valid), 0);
        for (int i = 0; i < 9; i++) check_val($sformatf("rst_w%0d", i + 1), int'(d0_w[i]), 0);
        q0.delete();
        q1.delete();
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_val("rst_in_ready", int'(d0_in_ready), 1);
    endtask

    // Drive npix pixels (value base+n+1); for a full frame wait for all N windows.
    task automatic run_frame(input int base, input int npix, input int stall_at, input bit tog);
        int n = 0;
        int cyc = 0;
        int t0 = total0;
        bit hs;
        bit stall;
        logic signed [8:0] snap [9];
        for (int k = 0; k < N; k++) begin
            q0.push_back(model(base, k, 0));
            q1.push_back(model(base, k, -256));
        end
        while (1) begin
            stall = (stall_at >= 0) && (cyc >= stall_at) && (cyc < stall_at + 5);
            in_valid = (n < npix);
            in_data = 9'(base + n + 1);
            if (stall) out_ready = 1'b0;
            else if (tog && n >= npix) out_ready = cyc[0];
            else out_ready = 1'b1;
            #1;
            if (stall) begin
                check_val("stall_in_ready", int'(d0_in_ready), 0);
                check_val("stall_out_valid", int'(d0_valid), 1);
                if (cyc == stall_at) begin
                    for (int i = 0; i < 9; i++) snap[i] = d0_w[i];
                end else begin
                    for (int i = 0; i < 9; i++)
                        check_val($sformatf("stall_hold_w%0d", i + 1), int'(d0_w[i]), int'(snap[i]));
                end
            end
            if (tog && n >= npix && total0 < t0 + N && !(d0_valid && d0_last))
                check_val("flush_in_ready", int'(d0_in_ready), 0);
            @(negedge clk);
            hs = in_valid && d0_in_ready;
            @(posedge clk);
            #1;
            if (hs) n++;
            cyc++;
            if (npix == N && total0 >= t0 + N) break;
            if (npix < N && n >= npix) break;
            if (cyc > 400) begin
                check_val("frame_timeout", total0 - t0, N);
                break;
            end
        end
        in_valid = 1'b0;
        if (npix == N) begin
            check_val("window_count", total0 - t0, N);
            check_val("queue_empty", q0.size(), 0);
        end
    endtask

    initial begin
        int ref_v [9];
        int ta, tb_, td;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        do_reset();

        // Frame A: 1..12, unstalled
        ta = total0;
        run_frame(0, N, -1, 1'b0);
        // Frame B: 101..112 back-to-back, downstream stalled 5 cycles mid-run
        tb_ = total0;
        run_frame(100, N, 8, 1'b0);
        // Frame C: out_ready toggles through the flush
        run_frame(200, N, -1, 1'b1);

        ref_v = '{0, 0, 0, 0, 1, 2, 0, 5, 6};
        check_lit("A_c00", log0[ta + 0], ref_v);
        ref_v = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
        check_lit("A_c11", log0[ta + 5], ref_v);
        ref_v = '{7, 8, 0, 11, 12, 0, 0, 0, 0};
        check_lit("A_c23", log0[ta + 11], ref_v);
        check_val("A_c23_last", int'(log0[ta + 11].last), 1);
        ref_v = '{-256, -256, -256, 3, 4, -256, 7, 8, -256};
        check_lit("A_b256_c03", log1[ta + 3], ref_v);
        ref_v = '{0, 0, 0, 0, 101, 102, 0, 105, 106};
        check_lit("B_c00", log0[tb_ + 0], ref_v);

        // Abort after 7 pixels, reset, then a clean frame
        run_frame(0, 7, -1, 1'b0);
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        do_reset();
        td = total0;
        run_frame(0, N, -1, 1'b0);
        ref_v = '{0, 0, 0, 0, 1, 2, 0, 5, 6};
        check_lit("D_c00", log0[td + 0], ref_v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_cnn_window_gen
